// File: rtl/shear_sort_pe.sv
// Mesh PE for snake-order shearsort: holds one {addr,data} record and does odd-even transposition with its l/r/u/d neighbours.
// Latency: start at edge k, steps run at edges k+1..k+T, T = (2*log2(N)+1)*N, and o_done rises at edge k+T.
// No backpressure: all PEs run in lockstep, and load/start are ignored while busy.
module shear_sort_pe #(
    parameter int N          = 4,
    parameter int ROW        = 0,
    parameter int COL        = 0,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_load,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_load_data,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_l,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_r,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_u,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_d,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
    output logic                             o_busy,
    output logic                             o_done
);
    localparam int REC_W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int SW     = $clog2(N);
    localparam int PHASES = $clog2(N) + 1;
    localparam int PH_W   = $clog2(PHASES);

    localparam logic [SW-1:0]   LAST_STEP  = SW'(N - 1);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PHASES - 1);

    // Position of this PE inside its row (COL) and inside its column (ROW).
    localparam logic ROW_ODD   = (ROW % 2 == 1);
    localparam logic COL_ODD   = (COL % 2 == 1);
    localparam logic ROW_FIRST = (ROW == 0);
    localparam logic COL_FIRST = (COL == 0);
    localparam logic ROW_LAST  = (ROW == N - 1);
    localparam logic COL_LAST  = (COL == N - 1);

    typedef enum logic [1:0] {IDLE, ROWP, COLP, DONE} state_t;

    state_t            state, state_n;
    logic [SW-1:0]     step, step_n;
    logic [PH_W-1:0]   phase, phase_n;
    logic [REC_W-1:0]  pe_q, pe_n;

    logic              is_row, p_lsb, p_first, p_last, desc;
    logic              use_next, use_prev, want_min, nb_lt;
    logic [REC_W-1:0]  nb, step_rec;

    // Sort key puts data above addr so equal data falls back to the lower addr.
    function automatic logic [REC_W-1:0] rec_key(input logic [REC_W-1:0] r);
        return {r[DATA_WIDTH-1:0], r[REC_W-1:DATA_WIDTH]};
    endfunction

    // One compare-exchange step: pick the partner, then keep the min or max side.
    always_comb begin
        is_row   = (state == ROWP);
        p_lsb    = is_row ? COL_ODD   : ROW_ODD;
        p_first  = is_row ? COL_FIRST : ROW_FIRST;
        p_last   = is_row ? COL_LAST  : ROW_LAST;
        desc     = is_row && ROW_ODD;
        use_next = (p_lsb == step[0]) && !p_last;
        use_prev = (p_lsb != step[0]) && !p_first;
        nb       = use_next ? (is_row ? i_PE_r : i_PE_d)
                            : (is_row ? i_PE_l : i_PE_u);
        // The lower-index PE keeps the min, except in odd rows where the order is reversed.
        want_min = use_next ? !desc : desc;
        nb_lt    = rec_key(nb) < rec_key(pe_q);
        step_rec = pe_q;
        if (use_next || use_prev) begin
            if (want_min) begin
                step_rec = nb_lt ? nb : pe_q;
            end else begin
                step_rec = nb_lt ? pe_q : nb;
            end
        end
    end

    // Next-state logic: load/start in IDLE/DONE, step and phase sequencing while busy.
    always_comb begin
        state_n = state;
        step_n  = step;
        phase_n = phase;
        pe_n    = pe_q;
        case (state)
            IDLE, DONE: begin
                if (i_load) begin
                    pe_n    = i_load_data;
                    state_n = IDLE;
                end
                if (i_start) begin
                    state_n = ROWP;
                    step_n  = '0;
                    phase_n = '0;
                end
            end
            ROWP: begin
                pe_n   = step_rec;
                step_n = step + SW'(1);
                if (step == LAST_STEP) begin
                    state_n = (phase == LAST_PHASE) ? DONE : COLP;
                end
            end
            COLP: begin
                pe_n   = step_rec;
                step_n = step + SW'(1);
                if (step == LAST_STEP) begin
                    phase_n = phase + PH_W'(1);
                    state_n = ROWP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and record register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            step  <= '0;
            phase <= '0;
            pe_q  <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
            phase <= phase_n;
            pe_q  <= pe_n;
        end
    end

    assign o_PE   = pe_q;
    assign o_busy = (state == ROWP) || (state == COLP);
    assign o_done = (state == DONE);

endmodule

// File: tb/tb_shear_sort_pe.sv
// Directed bench: single 2x2-parameter PEs against fixed neighbours, plus a full 4x4 mesh.
// Checks first-step results, tie-breaking, done timing, final snake order, reset and ignored commands.
// All expected values are hand-derived constants or computed from the snake-order definition.
module tb_shear_sort_pe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single PE A: N=2, ROW=0, COL=0 (ascending row, lower index).
    logic       a_load = 1'b0, a_start = 1'b0;
    logic [5:0] a_ld = '0, a_r = '0;
    logic [5:0] a_pe;
    logic       a_busy, a_done;
    shear_sort_pe #(.N(2), .ROW(0), .COL(0), .ADDR_WIDTH(3), .DATA_WIDTH(3)) u_pe_a (
        .clk(clk), .rst(rst), .i_load(a_load), .i_load_data(a_ld), .i_start(a_start),
        .i_PE_l(6'd0), .i_PE_r(a_r), .i_PE_u(6'd0), .i_PE_d(6'd0),
        .o_PE(a_pe), .o_busy(a_busy), .o_done(a_done));

    // Single PE B: N=2, ROW=1, COL=0 (descending row).
    logic       b_load = 1'b0, b_start = 1'b0;
    logic [5:0] b_ld = '0, b_r = '0;
    logic [5:0] b_pe;
    logic       b_busy, b_done;
    shear_sort_pe #(.N(2), .ROW(1), .COL(0), .ADDR_WIDTH(3), .DATA_WIDTH(3)) u_pe_b (
        .clk(clk), .rst(rst), .i_load(b_load), .i_load_data(b_ld), .i_start(b_start),
        .i_PE_l(6'd0), .i_PE_r(b_r), .i_PE_u(6'd0), .i_PE_d(6'd0),
        .o_PE(b_pe), .o_busy(b_busy), .o_done(b_done));

    // 4x4 mesh with 4-bit addr and data.
    logic        m_load = 1'b0, m_start = 1'b0;
    logic [7:0]  m_ld [16];
    logic [7:0]  m_pe [16];
    logic [15:0] m_busy, m_done;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int IX = r * 4 + c;
            localparam int LI = (c > 0) ? IX - 1 : IX;
            localparam int RI = (c < 3) ? IX + 1 : IX;
            localparam int UI = (r > 0) ? IX - 4 : IX;
            localparam int DI = (r < 3) ? IX + 4 : IX;
            shear_sort_pe #(.N(4), .ROW(r), .COL(c), .ADDR_WIDTH(4), .DATA_WIDTH(4)) u_pe (
                .clk(clk), .rst(rst), .i_load(m_load), .i_load_data(m_ld[IX]), .i_start(m_start),
                .i_PE_l(m_pe[LI]), .i_PE_r(m_pe[RI]), .i_PE_u(m_pe[UI]), .i_PE_d(m_pe[DI]),
                .o_PE(m_pe[IX]), .o_busy(m_busy[IX]), .o_done(m_done[IX]));
        end
    end

    // Raster order: PE i gets addr=i, data=15-i.
    task automatic mesh_load;
        for (int i = 0; i < 16; i++) m_ld[i] = {4'(i), 4'(15 - i)};
        m_load = 1'b1;
        tick;
        m_load = 1'b0;
    endtask

    // Expected row contents in snake order; data d carries addr 15-d.
    function automatic logic [31:0] exp_row(input int r);
        logic [31:0] v;
        int d;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            d = (r % 2 == 0) ? r * 4 + c : r * 4 + 3 - c;
            v[c*8 +: 8] = {4'(15 - d), 4'(d)};
        end
        return v;
    endfunction

    function automatic logic [31:0] act_row(input int r);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) v[c*8 +: 8] = m_pe[r*4 + c];
        return v;
    endfunction

    task automatic check_sorted(input string tag);
        for (int r = 0; r < 4; r++) chk($sformatf("%s_row%0d", tag, r), act_row(r), exp_row(r));
    endtask

    // Start the mesh and record the first cycle after the start edge where every o_done is high.
    // inject_at>0 asserts load(all ones)+start on that cycle, which must be ignored.
    task automatic mesh_run(input string tag, input int inject_at);
        int  first_n;
        logic hit_ff;
        first_n = 0;
        hit_ff  = 1'b0;
        m_start = 1'b1;
        tick;
        m_start = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (n == inject_at) begin
                for (int i = 0; i < 16; i++) m_ld[i] = 8'hFF;
                m_load  = 1'b1;
                m_start = 1'b1;
            end
            tick;
            m_load  = 1'b0;
            m_start = 1'b0;
            if (inject_at > 0 && n == inject_at + 1) begin
                for (int i = 0; i < 16; i++) if (m_pe[i] == 8'hFF) hit_ff = 1'b1;
                chk({tag, "_load_ignored"}, 32'(hit_ff), 32'd0);
            end
            if (first_n == 0 && m_done == 16'hFFFF) first_n = n;
        end
        chk({tag, "_done_cycle"}, 32'(first_n), 32'd20);
        chk({tag, "_busy_after"}, 32'(m_busy), 32'd0);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_a_pe", 32'(a_pe), 32'd0);
        chk("rst_a_flags", {30'd0, a_busy, a_done}, 32'd0);
        chk("rst_mesh_busy_done", {m_busy, m_done}, 32'd0);
        rst = 1'b1;

        // Single PE, first step swaps with the smaller right neighbour.
        a_r = 6'b000_010; a_ld = 6'b001_101; a_load = 1'b1;
        tick;
        a_load = 1'b0;
        chk("a_loaded", 32'(a_pe), 32'b001_101);
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        tick;
        chk("a_step0", 32'(a_pe), 32'b000_010);
        chk("a_busy", 32'(a_busy), 32'd1);
        for (int n = 2; n <= 5; n++) tick;
        chk("a_done_k5", 32'(a_done), 32'd0);
        tick;
        chk("a_done_k6", 32'(a_done), 32'd1);
        chk("a_busy_k6", 32'(a_busy), 32'd0);

        // Descending row: lower-index PE keeps the max.
        b_r = 6'b000_101; b_ld = 6'b000_010; b_load = 1'b1; b_start = 1'b1;
        tick;
        b_load = 1'b0; b_start = 1'b0;
        tick;
        chk("b_desc_step0", 32'(b_pe), 32'b000_101);

        // Tie on data: lower addr lands on the min side. Loading from DONE clears o_done.
        a_r = 6'b001_100; a_ld = 6'b011_100; a_load = 1'b1;
        tick;
        a_load = 1'b0;
        chk("a_load_clears_done", 32'(a_done), 32'd0);
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        tick;
        chk("a_tie", 32'(a_pe), 32'b001_100);

        // Full mesh sort.
        mesh_load;
        mesh_run("mesh1", 0);
        check_sorted("mesh1");

        // Reset mid-sort, then reload and sort again.
        mesh_load;
        m_start = 1'b1;
        tick;
        m_start = 1'b0;
        for (int n = 1; n <= 7; n++) tick;
        chk("mesh_busy_before_rst", 32'(m_busy), 32'hFFFF);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        begin
            logic any_nz;
            any_nz = 1'b0;
            for (int i = 0; i < 16; i++) if (m_pe[i] != 8'd0) any_nz = 1'b1;
            chk("mesh_rst_pe_zero", 32'(any_nz), 32'd0);
        end
        chk("mesh_rst_flags", {m_busy, m_done}, 32'd0);
        mesh_load;
        mesh_run("mesh2", 0);
        check_sorted("mesh2");

        // Load+start mid-sort are ignored.
        mesh_load;
        mesh_run("mesh3", 5);
        check_sorted("mesh3");

        // Restart from DONE without reload: already sorted data re-sorts to the same result.
        mesh_run("mesh4", 0);
        check_sorted("mesh4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
